banco_registros: RTL and testbench
==================================

Name: banco_registros

Overview:
Register file that consumes the destination address produced by the RegDst select (R-type rd vs I-type rt) and performs the write-back. It also serves the two operand reads of the decode stage. A pending-write scoreboard raises a stall when a source register still awaits its write-back. It sits between the decode stage (read side) and the write-back stage (write side) of the MIPS datapath.

Parameters:
ANCHO, 32, data width in bits
NREG, 32, number of architectural registers
DIR, 5, address width; NREG must equal 2**DIR

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-low reset
ra1  input  DIR  read address port 1 (rs)
ra2  input  DIR  read address port 2 (rt)
rd1  output  ANCHO  read data port 1
rd2  output  ANCHO  read data port 2
we  input  1  write enable from write-back
wa  input  DIR  write address (RegDst select output)
wd  input  ANCHO  write data
iss  input  1  instruction issued with a register destination
iss_dst  input  DIR  destination of the issued instruction
stall  output  1  a source register has a write still pending
pend  output  NREG  pending-write bit vector, for debug and verification

Behaviour:
- Reset: one synchronous edge with rst=0 clears all NREG registers to 0 and clears pend to 0. stall=0 and rd1=rd2=0 for any addresses after reset. rst=0 overrides we and iss in the same cycle.
- Register 0: always reads 0. Writes to wa=0 are ignored. iss_dst=0 never sets a pending bit. A read of address 0 never causes a stall.
- Write: on a clk edge with rst=1 and we=1 and wa!=0, reg[wa] takes wd. Write latency is 1 cycle.
- Read: combinational from ra1/ra2. rd1/rd2 have no pipeline registers.
- Bypass: if we=1, wa!=0 and wa==ra1 in the same cycle, rd1=wd rather than the stored value. The same rule applies to ra2/rd2 and to both ports at once.
- Scoreboard, per register i (i!=0), on each edge:
  - set when iss=1 and iss_dst==i;
  - clear when we=1 and wa==i;
  - when set and clear hit the same register in the same cycle, set wins and the bit stays 1, because a new producer supersedes the completing one.
- A write to a register whose pending bit is 0 is legal. It updates the register and leaves the bit at 0.
- stall is combinational. stall=1 when (pend[ra1] and not bypassed) or (pend[ra2] and not bypassed).
  - "Bypassed" means we=1 and wa equals that read address in the current cycle.
  - ra=0 never stalls.
- Port 2 always participates in stall. Masking ra2 for I-type instructions is the decode stage's job.
- Stalled cycles do not change storage. The issuing logic must hold iss=0 while stall=1; the block does not check this.
- Reset mid-operation: all pending bits drop and register contents go to 0. A concurrent write in the reset cycle is lost.

Decomposition:
- Shared package or include: ANCHO, DIR, NREG, and the register index constant REG_ZERO=0.
- One natural sub-module: marcador_pendientes. It holds the pend vector, the set/clear/priority logic and the stall compare.
- The storage array and the bypass muxes stay in banco_registros.

Test Plan:
- Reset then reads: assert rst=0 for 1 edge, release, read ra1=5, ra2=31 -> rd1=0, rd2=0, stall=0, pend=0.
- Write/readback: we=1, wa=8, wd=32'hDEADBEEF, ra1=8 in the same cycle -> rd1=32'hDEADBEEF via bypass. Next cycle with we=0 -> rd1 still 32'hDEADBEEF.
- Zero register: we=1, wa=0, wd=32'hFFFFFFFF; iss=1, iss_dst=0 -> next cycle rd1(ra1=0)=0, pend[0]=0, stall=0.
- Hazard lifecycle: iss=1, iss_dst=9 -> pend[9]=1. Next cycle ra2=9 -> stall=1. Write-back we=1, wa=9, wd=7 -> stall=0 in that cycle with rd2=7. Following cycle pend[9]=0.
- Set/clear collision: pend[12]=1, then iss=1, iss_dst=12 and we=1, wa=12, wd=3 in the same cycle -> reg[12]=3 and pend[12] remains 1.
- Reset mid-operation: pend[4]=1 and reg[4]=5. Assert rst=0 with we=1, wa=4, wd=9 -> next cycle reg[4]=0, pend=0, stall=0.

Source files
------------

// File: rtl/banco_registros_pkg.sv
// Shared sizes and constants for the register file and its pending-write scoreboard.
package banco_registros_pkg;

  localparam int ANCHO    = 32;
  localparam int DIR      = 5;
  localparam int NREG     = 32;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/banco_registros_marcador_pendientes.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at write-back,
// plus the stall compare for the two decode-stage source addresses.
//
// bit state | meaning
// ----------+------------------------------------------------------------
// 0         | register value in the file (or on the write port) is current
// 1         | an issued instruction will still write this register
module marcador_pendientes
  import banco_registros_pkg::*;
#(
  parameter int PDIR  = DIR,
  parameter int PNREG = NREG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PDIR-1:0]  ra1,
  input  logic [PDIR-1:0]  ra2,
  input  logic             we,
  input  logic [PDIR-1:0]  wa,
  input  logic             iss,
  input  logic [PDIR-1:0]  iss_dst,
  output logic             stall,
  output logic [PNREG-1:0] pend
);

  logic [PNREG-1:0] pend_nxt;
  logic             haz1;
  logic             haz2;

  // Next pending vector: a new producer supersedes one completing in the same cycle,
  // so the set is applied after the clear. Bit 0 is never tracked.
  always_comb begin
    pend_nxt = pend;
    if (we && (wa != PDIR'(REG_ZERO)))
      pend_nxt[wa] = 1'b0;
    if (iss && (iss_dst != PDIR'(REG_ZERO)))
      pend_nxt[iss_dst] = 1'b1;
  end

  // Pending vector register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst)
      pend <= '0;
    else
      pend <= pend_nxt;
  end

  // A source stalls only if still pending and not being written back this very cycle.
  always_comb begin
    haz1  = (ra1 != PDIR'(REG_ZERO)) && pend[ra1] && !(we && (wa == ra1));
    haz2  = (ra2 != PDIR'(REG_ZERO)) && pend[ra2] && !(we && (wa == ra2));
    stall = haz1 || haz2;
  end

endmodule

// File: rtl/banco_registros.sv
// MIPS register file: two combinational read ports with write-back bypass,
// one synchronous write port, and a pending-write scoreboard driving stall.
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int PANCHO = ANCHO,
  parameter int PNREG  = NREG,
  parameter int PDIR   = DIR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PDIR-1:0]   ra1,
  input  logic [PDIR-1:0]   ra2,
  output logic [PANCHO-1:0] rd1,
  output logic [PANCHO-1:0] rd2,
  input  logic              we,
  input  logic [PDIR-1:0]   wa,
  input  logic [PANCHO-1:0] wd,
  input  logic              iss,
  input  logic [PDIR-1:0]   iss_dst,
  output logic              stall,
  output logic [PNREG-1:0]  pend
);

  logic [PANCHO-1:0] regs [PNREG];
  logic              wr_ok;

  assign wr_ok = we && (wa != PDIR'(REG_ZERO));

  // Storage: reset clears every entry; entry 0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PNREG; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // Read ports: zero register, then same-cycle write-back bypass, then stored value.
  always_comb begin
    if (ra1 == PDIR'(REG_ZERO))
      rd1 = '0;
    else if (wr_ok && (wa == ra1))
      rd1 = wd;
    else
      rd1 = regs[ra1];

    if (ra2 == PDIR'(REG_ZERO))
      rd2 = '0;
    else if (wr_ok && (wa == ra2))
      rd2 = wd;
    else
      rd2 = regs[ra2];
  end

  marcador_pendientes #(
    .PDIR  (PDIR),
    .PNREG (PNREG)
  ) u_marcador (
    .clk     (clk),
    .rst     (rst),
    .ra1     (ra1),
    .ra2     (ra2),
    .we      (we),
    .wa      (wa),
    .iss     (iss),
    .iss_dst (iss_dst),
    .stall   (stall),
    .pend    (pend)
  );

endmodule

// File: tb/tb_banco_registros.sv
// Bench for banco_registros: behavioural model feeds a scoreboard queue of expected
// read data / stall / pending vector, drained after the combinational outputs settle.
module tb_banco_registros;
  import banco_registros_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIR-1:0]   ra1, ra2, wa, iss_dst;
  logic [ANCHO-1:0] rd1, rd2, wd;
  logic             we, iss, stall;
  logic [NREG-1:0]  pend;

  always #5 clk = ~clk;

  banco_registros dut (
    .clk     (clk),
    .rst     (rst),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .iss     (iss),
    .iss_dst (iss_dst),
    .stall   (stall),
    .pend    (pend)
  );

  typedef enum {K_RD1, K_RD2, K_STALL, K_PEND} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    logic [63:0] exp;
  } exp_t;

  exp_t             sb[$];
  int               total = 0;
  int               bad   = 0;
  logic [ANCHO-1:0] m_reg [NREG];
  logic [NREG-1:0]  m_pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input kind_t k);
    case (k)
      K_RD1:   return 64'(rd1);
      K_RD2:   return 64'(rd2);
      K_STALL: return 64'(stall);
      default: return 64'(pend);
    endcase
  endfunction

  function automatic logic [ANCHO-1:0] m_read(input logic [DIR-1:0] a);
    if (a == 0) return '0;
    if (we && wa != 0 && wa == a) return wd;
    return m_reg[a];
  endfunction

  function automatic logic m_haz(input logic [DIR-1:0] a);
    return (a != 0) && m_pend[a] && !(we && wa == a);
  endfunction

  // One cycle: drive at negedge, check settled outputs, then advance the model at posedge.
  task automatic step(input string tag, input logic r, input logic w, input logic [DIR-1:0] a,
                      input logic [ANCHO-1:0] d, input logic is, input logic [DIR-1:0] dst,
                      input logic [DIR-1:0] a1, input logic [DIR-1:0] a2);
    exp_t e;
    rst = r; we = w; wa = a; wd = d; iss = is; iss_dst = dst; ra1 = a1; ra2 = a2;
    #1;
    sb.push_back('{{tag, ".rd1"},   K_RD1,   64'(m_read(ra1))});
    sb.push_back('{{tag, ".rd2"},   K_RD2,   64'(m_read(ra2))});
    sb.push_back('{{tag, ".stall"}, K_STALL, 64'(m_haz(ra1) || m_haz(ra2))});
    sb.push_back('{{tag, ".pend"},  K_PEND,  64'(m_pend)});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.kind), e.exp);
    end
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < NREG; i++) m_reg[i] = '0;
      m_pend = '0;
    end else begin
      if (w && a != 0) begin
        m_reg[a] = d;
        m_pend[a] = 1'b0;
      end
      if (is && dst != 0) m_pend[dst] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; wa = '0; wd = '0; iss = 1'b0; iss_dst = '0; ra1 = '0; ra2 = '0;
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_pend = '0;
    @(posedge clk);
    @(negedge clk);

    // reset then reads
    step("rst_read", 1, 0, 0, 0, 0, 0, 5, 31);
    chk("rst_pend", 64'(pend), 64'd0);

    // write with same-cycle bypass, then stored readback
    step("wr_byp", 1, 1, 8, 32'hDEADBEEF, 0, 0, 8, 0);
    step("wr_rb",  1, 0, 0, 0, 0, 0, 8, 8);
    chk("wr_rb_const", 64'(rd1), 64'hDEADBEEF);

    // zero register: write and issue to 0 are ignored
    step("zero_wr", 1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    step("zero_rd", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("zero_pend0", 64'(pend[0]), 64'd0);

    // hazard lifecycle on r9
    step("haz_iss",   1, 0, 0, 0, 1, 9, 0, 0);
    chk("haz_pend9", 64'(pend[9]), 64'd1);
    step("haz_stall", 1, 0, 0, 0, 0, 0, 0, 9);
    chk("haz_stall_const", 64'(stall), 64'd1);
    step("haz_wb",    1, 1, 9, 7, 0, 0, 0, 9);
    step("haz_done",  1, 0, 0, 0, 0, 0, 9, 9);
    chk("haz_pend9_clr", 64'(pend[9]), 64'd0);

    // set/clear collision on r12: set wins, data still written
    step("col_iss",  1, 0, 0, 0, 1, 12, 0, 0);
    step("col_both", 1, 1, 12, 3, 1, 12, 0, 0);
    step("col_chk",  1, 0, 0, 0, 0, 0, 0, 0);
    chk("col_pend12", 64'(pend[12]), 64'd1);
    step("col_byp",  1, 1, 12, 32'h55, 0, 0, 12, 12);
    step("col_rd",   1, 0, 0, 0, 0, 0, 12, 0);

    // bypass on both ports at once
    step("dual_byp", 1, 1, 20, 32'hA5A5_0001, 0, 0, 20, 20);

    // reset mid-operation drops a concurrent write and all pending bits
    step("mid_wr",  1, 1, 4, 5, 0, 0, 0, 0);
    step("mid_iss", 1, 0, 0, 0, 1, 4, 4, 0);
    step("mid_rst", 0, 1, 4, 9, 1, 6, 4, 4);
    step("mid_chk", 1, 0, 0, 0, 0, 0, 4, 8);
    chk("mid_pend", 64'(pend), 64'd0);

    // randomised traffic against the model
    for (int n = 0; n < 300; n++) begin
      step("rnd",
           ($urandom_range(0, 59) != 0),
           ($urandom_range(0, 1) == 1),
           DIR'($urandom_range(0, 7)),
           $urandom(),
           ($urandom_range(0, 2) == 0),
           DIR'($urandom_range(0, 7)),
           DIR'($urandom_range(0, 7)),
           DIR'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
